fmap_reader: RTL

FMAP_READER -- requirements
Module: fmap_reader

---
 rtl/fmap_reader_pkg.sv | 31 +++
 rtl/fmap_fifo2.sv | 60 ++++++
 rtl/fmap_reader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fmap_reader_pkg.sv
// Shared definitions for the feature-map reader.
// Holds the FSM state encoding, the padding border size and helpers that
// derive the streamed geometry and beat count from the map dimensions.
// Optional feature macro: FMAP_READER_PAD_EN (one-pixel zero border).
package fmap_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

`ifdef FMAP_READER_PAD_EN
  // One border pixel on each side of every row and column
  localparam int unsigned PadCells = 2;
`else
  localparam int unsigned PadCells = 0;
`endif

  // Streamed extent of one map dimension
  function automatic int unsigned stream_dim(input int unsigned n);
    return n + PadCells;
  endfunction

  // Total beats streamed for one map of the configured geometry
  function automatic int unsigned beat_count(input int unsigned h, input int unsigned w);
    return stream_dim(h) * stream_dim(w);
  endfunction

endpackage

// File: rtl/fmap_fifo2.sv
// Two-entry output FIFO for the feature-map reader.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   push_i, wdata_i    write strobe and payload {data, last, eof}
//   pop_i              remove head entry
//   rdata_o            head entry (stable until popped)
//   full_o, empty_o    occupancy flags
module fmap_fifo2 #(
  parameter int unsigned Width = 34
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves the same cycle
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Storage, pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fmap_reader.sv
// Feature-map reader: streams one Map_H x Map_W map from memory in raster
// order through a 2-entry output FIFO with a valid/ready handshake.
// Optional feature macro: FMAP_READER_PAD_EN adds a one-pixel zero border
// (border beats issue no memory read).
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   start, base_addr    stream request and map start address
//   busy, done          stream in progress / one-cycle completion pulse
//   mem_rd_en, mem_addr memory read strobe and address
//   mem_rd_data         read data, valid one cycle after mem_rd_en
//   out_data/valid/ready/last/eof  output beat stream
module fmap_reader
  import fmap_reader_pkg::*;
#(
  parameter int unsigned Data_Width = 32,
  parameter int unsigned Addr_Width = 10,
  parameter int unsigned Map_H      = 28,
  parameter int unsigned Map_W      = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [Addr_Width-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [Addr_Width-1:0] mem_addr,
  input  logic [Data_Width-1:0] mem_rd_data,
  output logic [Data_Width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  out_eof
);

  localparam int unsigned StreamW  = stream_dim(Map_W);
  localparam int unsigned NumBeats = beat_count(Map_H, Map_W);
  localparam int unsigned ColW     = $clog2(StreamW + 1);
  localparam int unsigned BeatW    = $clog2(NumBeats + 1);
  localparam int unsigned PayW     = Data_Width + 2;

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [Addr_Width-1:0] addr_q;
  logic [ColW-1:0]       col_q;
  logic [BeatW-1:0]      idx_q;
  // A beat slot issued last cycle lands in the FIFO this cycle
  logic                  pend_q;
  logic                  pend_last_q;
  logic                  pend_eof_q;

`ifdef FMAP_READER_PAD_EN
  localparam int unsigned StreamH = stream_dim(Map_H);
  localparam int unsigned RowW    = $clog2(StreamH + 1);
  logic [RowW-1:0]       row_q;
  logic                  pend_border_q;
`endif

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PayW-1:0]       fifo_wdata;
  logic [PayW-1:0]       fifo_rdata;
  logic                  pop_c;
  logic                  issue_c;
  logic                  border_c;
  logic                  beat_last_c;
  logic                  beat_eof_c;
  logic [1:0]            occ_c;
  logic [2:0]            fill_c;
  logic [Data_Width-1:0] push_data_c;

  // Issue decision: FIFO occupancy plus the in-flight slot, less this
  // cycle's pop, must leave room so no returning beat can be dropped
  always_comb begin
    pop_c       = !fifo_empty && out_ready;
    occ_c       = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    fill_c      = 3'(occ_c) + 3'(pend_q) - 3'(pop_c);
    issue_c     = reset && (state_q == ST_READ) && (fill_c < 3'd2);
    beat_last_c = (col_q == ColW'(StreamW - 1));
    beat_eof_c  = (idx_q == BeatW'(NumBeats - 1));
`ifdef FMAP_READER_PAD_EN
    border_c    = (row_q == '0) || (row_q == RowW'(StreamH - 1)) ||
                  (col_q == '0) || beat_last_c;
    push_data_c = pend_border_q ? '0 : mem_rd_data;
`else
    border_c    = 1'b0;
    push_data_c = mem_rd_data;
`endif
  end

  assign fifo_wdata = {push_data_c, pend_last_q, pend_eof_q};

  fmap_fifo2 #(
    .Width (PayW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (pend_q),
    .pop_i   (pop_c),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd_en = issue_c && !border_c;
  assign mem_addr  = addr_q;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata[PayW-1:2];
  // Tags are masked so a stale head never shows last/eof without valid
  assign out_last  = !fifo_empty && fifo_rdata[1];
  assign out_eof   = !fifo_empty && fifo_rdata[0];

  // Control FSM, raster counters and in-flight slot tracking
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      addr_q        <= '0;
      col_q         <= '0;
      idx_q         <= '0;
      pend_q        <= 1'b0;
      pend_last_q   <= 1'b0;
      pend_eof_q    <= 1'b0;
`ifdef FMAP_READER_PAD_EN
      row_q         <= '0;
      pend_border_q <= 1'b0;
`endif
    end else begin
      pend_q <= issue_c;
      if (issue_c) begin
        pend_last_q   <= beat_last_c;
        pend_eof_q    <= beat_eof_c;
`ifdef FMAP_READER_PAD_EN
        pend_border_q <= border_c;
`endif
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_READ;
            busy_q  <= 1'b1;
            addr_q  <= base_addr;
            col_q   <= '0;
            idx_q   <= '0;
`ifdef FMAP_READER_PAD_EN
            row_q   <= '0;
`endif
          end
        end
        ST_READ: begin
          if (issue_c) begin
            // Interior pixels are contiguous, so the address only advances on real reads
            if (!border_c) begin
              addr_q <= addr_q + Addr_Width'(1);
            end
            idx_q <= idx_q + BeatW'(1);
            if (beat_last_c) begin
              col_q <= '0;
`ifdef FMAP_READER_PAD_EN
              row_q <= row_q + RowW'(1);
`endif
            end else begin
              col_q <= col_q + ColW'(1);
            end
            if (beat_eof_c) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop_c && out_eof) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
